ysyx_24110015_bus_sched: RTL and testbench

Two-requester memory scheduler between the IFU (read-only) and the LSU (read/write) on one side, and a single downstream AXI4 master port on the other side. The downstream port feeds the xbar.
It accepts simple level-held requests and serialises them into single-beat AXI transactions. Only one transaction is outstanding at a time.
It returns a one-cycle completion pulse to the owning requester, and prevents IFU starvation with a bounded LSU streak.

---
 rtl/ysyx_24110015_bus_sched_if.sv | 62 ++++++
 rtl/ysyx_24110015_bus_sched.sv | 212 +++++++++++++++++++++
 tb/tb_ysyx_24110015_bus_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110015_bus_sched_if.sv
// Downstream single-beat AXI4 port between the bus scheduler (master) and the xbar (slave).
// Burst/size/id fields are carried so the xbar sees a complete AXI4 channel set.
interface ysyx_24110015_bus_sched_if #(
   parameter int ADDR_W = 32
);
   logic              m_arvalid;
   logic              m_arready;
   logic [ADDR_W-1:0] m_araddr;
   logic [7:0]        m_arlen;
   logic [2:0]        m_arsize;
   logic [1:0]        m_arburst;
   logic [3:0]        m_arid;

   logic              m_rvalid;
   logic              m_rready;
   logic [31:0]       m_rdata;
   logic [1:0]        m_rresp;

   logic              m_awvalid;
   logic              m_awready;
   logic [ADDR_W-1:0] m_awaddr;
   logic [7:0]        m_awlen;
   logic [2:0]        m_awsize;
   logic [1:0]        m_awburst;
   logic [3:0]        m_awid;

   logic              m_wvalid;
   logic              m_wready;
   logic [31:0]       m_wdata;
   logic [3:0]        m_wstrb;
   logic              m_wlast;

   logic              m_bvalid;
   logic              m_bready;
   logic [1:0]        m_bresp;

   modport master (
      output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid,
      input  m_arready,
      input  m_rvalid, m_rdata, m_rresp,
      output m_rready,
      output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awid,
      input  m_awready,
      output m_wvalid, m_wdata, m_wstrb, m_wlast,
      input  m_wready,
      input  m_bvalid, m_bresp,
      output m_bready
   );

   modport slave (
      input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid,
      output m_arready,
      output m_rvalid, m_rdata, m_rresp,
      input  m_rready,
      input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awid,
      output m_awready,
      input  m_wvalid, m_wdata, m_wstrb, m_wlast,
      output m_wready,
      output m_bvalid, m_bresp,
      input  m_bready
   );
endinterface

// File: rtl/ysyx_24110015_bus_sched.sv
// IFU/LSU memory scheduler: serialises level-held requests into single-beat AXI4
// transactions, one outstanding at a time, with a bounded LSU streak so IFU cannot starve.
module ysyx_24110015_bus_sched #(
   parameter int MAX_LSU_STREAK = 4,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              ifu_req,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_done,
   output logic [31:0]       ifu_rdata,
   output logic              ifu_err,

   input  logic              lsu_req,
   input  logic              lsu_we,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [31:0]       lsu_wdata,
   input  logic [3:0]        lsu_wstrb,
   output logic              lsu_done,
   output logic [31:0]       lsu_rdata,
   output logic              lsu_err,

   ysyx_24110015_bus_sched_if.master m
);
   localparam int SW = (MAX_LSU_STREAK < 1) ? 1 : $clog2(MAX_LSU_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

   state_t            state_reg, state_next;
   logic [SW-1:0]     streak_reg, streak_next;
   logic              owner_reg, owner_next;      // 1 = LSU owns the transaction
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [31:0]       wdata_reg, wdata_next;
   logic [3:0]        wstrb_reg, wstrb_next;
   logic              arvalid_reg, arvalid_next;
   logic              awvalid_reg, awvalid_next;
   logic              wvalid_reg, wvalid_next;
   logic              rready_reg, rready_next;
   logic              bready_reg, bready_next;
   logic              aw_ok_reg, aw_ok_next;
   logic              w_ok_reg, w_ok_next;
   // Per-requester result registers, index 0 = IFU, 1 = LSU.
   logic [1:0][31:0]  rdata_reg, rdata_next;
   logic [1:0]        err_reg, err_next;
   logic [1:0]        done_reg, done_next;

   logic lsu_win, aw_fire, w_fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         streak_reg  <= '0;
         owner_reg   <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         wstrb_reg   <= '0;
         arvalid_reg <= 1'b0;
         awvalid_reg <= 1'b0;
         wvalid_reg  <= 1'b0;
         rready_reg  <= 1'b0;
         bready_reg  <= 1'b0;
         aw_ok_reg   <= 1'b0;
         w_ok_reg    <= 1'b0;
         rdata_reg   <= '0;
         err_reg     <= '0;
         done_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         streak_reg  <= streak_next;
         owner_reg   <= owner_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         wstrb_reg   <= wstrb_next;
         arvalid_reg <= arvalid_next;
         awvalid_reg <= awvalid_next;
         wvalid_reg  <= wvalid_next;
         rready_reg  <= rready_next;
         bready_reg  <= bready_next;
         aw_ok_reg   <= aw_ok_next;
         w_ok_reg    <= w_ok_next;
         rdata_reg   <= rdata_next;
         err_reg     <= err_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      streak_next  = streak_reg;
      owner_next   = owner_reg;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      wstrb_next   = wstrb_reg;
      arvalid_next = arvalid_reg;
      awvalid_next = awvalid_reg;
      wvalid_next  = wvalid_reg;
      rready_next  = rready_reg;
      bready_next  = bready_reg;
      aw_ok_next   = aw_ok_reg;
      w_ok_next    = w_ok_reg;
      rdata_next   = rdata_reg;
      err_next     = err_reg;
      done_next    = 2'b00;

      lsu_win = lsu_req && (!ifu_req || (streak_reg < STREAK_MAX));
      aw_fire = awvalid_reg && m.m_awready;
      w_fire  = wvalid_reg && m.m_wready;

      case (state_reg)
         IDLE: begin
            if (lsu_win) begin
               owner_next = 1'b1;
               addr_next  = lsu_addr;
               wdata_next = lsu_wdata;
               wstrb_next = lsu_wstrb;
               // Only a grant that makes a waiting IFU wait longer extends the streak.
               if (ifu_req)
                  streak_next = (streak_reg == STREAK_MAX) ? streak_reg : streak_reg + SW'(1);
               else
                  streak_next = '0;
               if (lsu_we) begin
                  state_next   = WREQ;
                  awvalid_next = 1'b1;
                  wvalid_next  = 1'b1;
                  aw_ok_next   = 1'b0;
                  w_ok_next    = 1'b0;
               end else begin
                  state_next   = RADDR;
                  arvalid_next = 1'b1;
               end
            end else if (ifu_req) begin
               owner_next   = 1'b0;
               addr_next    = ifu_addr;
               wstrb_next   = '0;
               streak_next  = '0;
               state_next   = RADDR;
               arvalid_next = 1'b1;
            end
         end
         RADDR: begin
            if (arvalid_reg && m.m_arready) begin
               arvalid_next = 1'b0;
               rready_next  = 1'b1;
               state_next   = RDATA;
            end
         end
         RDATA: begin
            if (m.m_rvalid && rready_reg) begin
               rready_next           = 1'b0;
               rdata_next[owner_reg] = m.m_rdata;
               err_next[owner_reg]   = (m.m_rresp != 2'b00);
               done_next[owner_reg]  = 1'b1;
               state_next            = DONE;
            end
         end
         WREQ: begin
            // AW and W complete independently; wait until both have been accepted.
            awvalid_next = awvalid_reg && !aw_fire;
            wvalid_next  = wvalid_reg && !w_fire;
            aw_ok_next   = aw_ok_reg || aw_fire;
            w_ok_next    = w_ok_reg || w_fire;
            if (aw_ok_next && w_ok_next) begin
               bready_next = 1'b1;
               state_next  = WRESP;
            end
         end
         WRESP: begin
            if (m.m_bvalid && bready_reg) begin
               bready_next          = 1'b0;
               err_next[owner_reg]  = (m.m_bresp != 2'b00);
               done_next[owner_reg] = 1'b1;
               state_next           = DONE;
            end
         end
         DONE: begin
            rdata_next = '0;
            err_next   = '0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign ifu_done  = done_reg[0];
   assign ifu_rdata = rdata_reg[0];
   assign ifu_err   = err_reg[0];
   assign lsu_done  = done_reg[1];
   assign lsu_rdata = rdata_reg[1];
   assign lsu_err   = err_reg[1];

   assign m.m_arvalid = arvalid_reg;
   assign m.m_araddr  = addr_reg;
   assign m.m_arlen   = 8'd0;
   assign m.m_arsize  = 3'b010;
   assign m.m_arburst = 2'b01;
   assign m.m_arid    = 4'd0;
   assign m.m_rready  = rready_reg;
   assign m.m_awvalid = awvalid_reg;
   assign m.m_awaddr  = addr_reg;
   assign m.m_awlen   = 8'd0;
   assign m.m_awsize  = 3'b010;
   assign m.m_awburst = 2'b01;
   assign m.m_awid    = 4'd0;
   assign m.m_wvalid  = wvalid_reg;
   assign m.m_wdata   = wdata_reg;
   assign m.m_wstrb   = wstrb_reg;
   assign m.m_wlast   = 1'b1;
   assign m.m_bready  = bready_reg;
endmodule

// File: tb/tb_ysyx_24110015_bus_sched.sv
// Bench for ysyx_24110015_bus_sched: AXI slave model with programmable ready delays,
// expected completions queued at request time and compared when done pulses appear.
module tb_ysyx_24110015_bus_sched;
   localparam int MAXS = 4;

   typedef struct packed {
      logic        lsu;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_req, ifu_done, ifu_err;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req, lsu_we, lsu_done, lsu_err;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wstrb;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   // Slave model controls
   int          ar_delay = 0, aw_delay = 0, w_delay = 0;
   bit          r_hold = 1'b0;
   logic [31:0] rdata_val = '0;
   logic [1:0]  rresp_val = '0, bresp_val = '0;
   int          ar_cnt, aw_cnt, w_cnt;
   bit          rd_pend, aw_got, w_got;

   ysyx_24110015_bus_sched_if #(.ADDR_W(32)) bus ();

   ysyx_24110015_bus_sched #(.MAX_LSU_STREAK(MAXS), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_done(ifu_done),
      .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_done(lsu_done),
      .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
      .m(bus)
   );

   always #5 clk = ~clk;

   // Ready is held at its idle level (high when delay is 0) and otherwise raised
   // after 'delay' cycles of the matching valid.
   always @(posedge clk) begin
      if (rst) begin
         bus.m_arready <= (ar_delay == 0);
         bus.m_awready <= (aw_delay == 0);
         bus.m_wready  <= (w_delay == 0);
         bus.m_rvalid  <= 1'b0;
         bus.m_rdata   <= '0;
         bus.m_rresp   <= '0;
         bus.m_bvalid  <= 1'b0;
         bus.m_bresp   <= '0;
         ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
         rd_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
         if (bus.m_arvalid && bus.m_arready) begin
            bus.m_arready <= (ar_delay == 0); ar_cnt <= 0; rd_pend <= 1'b1;
         end else if (bus.m_arvalid) begin
            ar_cnt <= ar_cnt + 1;
            if (ar_cnt + 1 == ar_delay) bus.m_arready <= 1'b1;
         end else begin
            bus.m_arready <= (ar_delay == 0); ar_cnt <= 0;
         end

         if (bus.m_awvalid && bus.m_awready) begin
            bus.m_awready <= (aw_delay == 0); aw_cnt <= 0; aw_got <= 1'b1;
         end else if (bus.m_awvalid) begin
            aw_cnt <= aw_cnt + 1;
            if (aw_cnt + 1 == aw_delay) bus.m_awready <= 1'b1;
         end else begin
            bus.m_awready <= (aw_delay == 0); aw_cnt <= 0;
         end

         if (bus.m_wvalid && bus.m_wready) begin
            bus.m_wready <= (w_delay == 0); w_cnt <= 0; w_got <= 1'b1;
         end else if (bus.m_wvalid) begin
            w_cnt <= w_cnt + 1;
            if (w_cnt + 1 == w_delay) bus.m_wready <= 1'b1;
         end else begin
            bus.m_wready <= (w_delay == 0); w_cnt <= 0;
         end

         if (bus.m_rvalid && bus.m_rready) begin
            bus.m_rvalid <= 1'b0;
         end else if (!bus.m_rvalid && !r_hold &&
                      (rd_pend || (bus.m_arvalid && bus.m_arready))) begin
            bus.m_rvalid <= 1'b1; bus.m_rdata <= rdata_val; bus.m_rresp <= rresp_val;
            rd_pend <= 1'b0;
         end

         if (bus.m_bvalid && bus.m_bready) begin
            bus.m_bvalid <= 1'b0;
         end else if (!bus.m_bvalid &&
                      (aw_got || (bus.m_awvalid && bus.m_awready)) &&
                      (w_got || (bus.m_wvalid && bus.m_wready))) begin
            bus.m_bvalid <= 1'b1; bus.m_bresp <= bresp_val;
            aw_got <= 1'b0; w_got <= 1'b0;
         end
      end
   end

   task automatic test_reset();
      checks++;
      if ({ifu_done, lsu_done, ifu_err, lsu_err, ifu_rdata, lsu_rdata, bus.m_arvalid,
           bus.m_awvalid, bus.m_wvalid, bus.m_rready, bus.m_bready, bus.m_araddr,
           bus.m_wdata, bus.m_wstrb} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got done=%b%b rdata=%h/%h valids=%b%b%b rb=%b%b addr=%h required all zero",
                  ifu_done, lsu_done, ifu_rdata, lsu_rdata, bus.m_arvalid, bus.m_awvalid,
                  bus.m_wvalid, bus.m_rready, bus.m_bready, bus.m_araddr);
      end
      checks++;
      if ({bus.m_arsize, bus.m_arburst, bus.m_arlen, bus.m_wlast} !== {3'b010, 2'b01, 8'd0, 1'b1}) begin
         errors++;
         $display("FAIL tie_offs: got size=%b burst=%b len=%h wlast=%b required 010/01/00/1",
                  bus.m_arsize, bus.m_arburst, bus.m_arlen, bus.m_wlast);
      end
   endtask

   // Zero-wait read: IDLE, RADDR, RDATA, DONE -> done seen 3 edges after the request.
   task automatic test_ifu_read();
      exp_t e;
      int   lat = 0;
      bit   got = 0, ar_seen = 0, lsu_spur = 0;
      rdata_val = 32'hDEADBEEF; rresp_val = 2'b00;
      ifu_addr = 32'h3000_0000; ifu_req = 1'b1;
      e.lsu = 1'b0; e.rdata = 32'hDEADBEEF; e.err = 1'b0; sb.push_back(e);
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (bus.m_arvalid && !ar_seen) begin
            ar_seen = 1;
            checks++;
            if (bus.m_araddr !== 32'h3000_0000) begin
               errors++; $display("FAIL ifu_araddr: got %h required 30000000", bus.m_araddr);
            end
         end
         if (lsu_done) lsu_spur = 1;
         if (ifu_done) begin lat = n; got = 1; break; end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL ifu_read_timeout: no ifu_done within 30 cycles"); end
      if (got && sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (lat != 3) begin errors++; $display("FAIL ifu_read_latency: got %0d required 3", lat); end
         checks++;
         if ({ifu_rdata, ifu_err} !== {e.rdata, e.err}) begin
            errors++; $display("FAIL ifu_read_data: got %h err=%b required %h err=%b", ifu_rdata, ifu_err, e.rdata, e.err);
         end
      end
      sb.delete();
      checks++;
      if (lsu_spur || lsu_rdata !== 32'h0) begin
         errors++; $display("FAIL ifu_read_lsu_quiet: got lsu_done_seen=%b lsu_rdata=%h required 0/0", lsu_spur, lsu_rdata);
      end
      ifu_req = 1'b0;
      @(negedge clk);
      checks++;
      if (ifu_done !== 1'b0) begin errors++; $display("FAIL ifu_done_single: got %b required 0", ifu_done); end
      @(negedge clk);
   endtask

   task automatic test_lsu_write();
      exp_t       e;
      logic [3:0] aw_v = '0, w_v = '0;
      int         lat = 0;
      bit         got = 0, ifu_spur = 0;
      aw_delay = 2; w_delay = 0; bresp_val = 2'b10;
      @(negedge clk);
      lsu_we = 1'b1; lsu_addr = 32'h8000_0010; lsu_wdata = 32'h12345678; lsu_wstrb = 4'b0011;
      lsu_req = 1'b1;
      e.lsu = 1'b1; e.rdata = 32'h0; e.err = 1'b1; sb.push_back(e);
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n <= 4) begin aw_v[n-1] = bus.m_awvalid; w_v[n-1] = bus.m_wvalid; end
         if (n == 1) begin
            checks++;
            if ({bus.m_awaddr, bus.m_wdata, bus.m_wstrb} !== {32'h8000_0010, 32'h12345678, 4'b0011}) begin
               errors++; $display("FAIL write_payload: got %h %h %b required 80000010 12345678 0011",
                                  bus.m_awaddr, bus.m_wdata, bus.m_wstrb);
            end
         end
         if (ifu_done) ifu_spur = 1;
         if (lsu_done) begin lat = n; got = 1; break; end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL write_timeout: no lsu_done within 30 cycles"); end
      checks++;
      if (aw_v !== 4'b0111) begin errors++; $display("FAIL awvalid_profile: got %b required 0111 (cycles 4..1)", aw_v); end
      checks++;
      if (w_v !== 4'b0001) begin errors++; $display("FAIL wvalid_profile: got %b required 0001 (cycles 4..1)", w_v); end
      if (got && sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (lat != 5) begin errors++; $display("FAIL write_latency: got %0d required 5", lat); end
         checks++;
         if ({lsu_err, lsu_rdata} !== {e.err, e.rdata}) begin
            errors++; $display("FAIL write_resp: got err=%b rdata=%h required err=%b rdata=%h", lsu_err, lsu_rdata, e.err, e.rdata);
         end
      end
      sb.delete();
      checks++;
      if (ifu_spur) begin errors++; $display("FAIL write_ifu_quiet: got ifu_done pulse required none"); end
      lsu_req = 1'b0; lsu_we = 1'b0;
      aw_delay = 0; bresp_val = 2'b00;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_arbitration();
      exp_t       e;
      logic [9:0] order = 10'b0111101111;   // bit k = 1 -> k-th grant goes to LSU
      int         run = 0, max_run = 0;
      bit         got;
      logic [31:0] exp_l, exp_i;
      rdata_val = 32'h0000_5A5A; rresp_val = 2'b00;
      for (int k = 0; k < 10; k++) begin
         e.lsu = order[k]; e.rdata = 32'h0000_5A5A; e.err = 1'b0; sb.push_back(e);
      end
      ifu_addr = 32'h3000_0100; lsu_addr = 32'h8000_0200; lsu_we = 1'b0;
      ifu_req = 1'b1; lsu_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         got = 0;
         for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (ifu_done || lsu_done) begin got = 1; break; end
         end
         checks++;
         if (!got) begin errors++; $display("FAIL arb_timeout: grant %0d never completed", k); break; end
         e = sb.pop_front();
         checks++;
         if ({lsu_done, ifu_done} !== {e.lsu, !e.lsu}) begin
            errors++; $display("FAIL arb_order_%0d: got lsu_done=%b ifu_done=%b required lsu=%b", k, lsu_done, ifu_done, e.lsu);
         end
         exp_l = e.lsu ? e.rdata : 32'h0;
         exp_i = e.lsu ? 32'h0 : e.rdata;
         checks++;
         if ({lsu_rdata, ifu_rdata} !== {exp_l, exp_i}) begin
            errors++; $display("FAIL arb_rdata_%0d: got lsu=%h ifu=%h required lsu=%h ifu=%h", k, lsu_rdata, ifu_rdata, exp_l, exp_i);
         end
         if (lsu_done) run++; else run = 0;
         if (run > max_run) max_run = run;
      end
      sb.delete();
      ifu_req = 1'b0; lsu_req = 1'b0;
      checks++;
      if (max_run > MAXS) begin errors++; $display("FAIL arb_streak: got %0d consecutive LSU grants required <= %0d", max_run, MAXS); end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_lsu_read_stall();
      exp_t e;
      int   ar_cycles = 0, dones = 0;
      bit   addr_bad = 0;
      ar_delay = 5;
      @(negedge clk);
      rdata_val = 32'hCAFEF00D; lsu_we = 1'b0; lsu_addr = 32'h8000_0100; lsu_req = 1'b1;
      e.lsu = 1'b1; e.rdata = 32'hCAFEF00D; e.err = 1'b0; sb.push_back(e);
      for (int n = 1; n <= 25; n++) begin
         @(negedge clk);
         if (bus.m_arvalid) begin
            ar_cycles++;
            if (bus.m_araddr !== 32'h8000_0100) addr_bad = 1;
         end
         lsu_addr = lsu_addr + 32'h4;
         if (lsu_done) begin
            dones++;
            lsu_req = 1'b0;
            if (dones == 1 && sb.size() > 0) begin
               e = sb.pop_front();
               checks++;
               if ({lsu_rdata, lsu_err} !== {e.rdata, e.err}) begin
                  errors++; $display("FAIL stall_rdata: got %h err=%b required %h err=%b", lsu_rdata, lsu_err, e.rdata, e.err);
               end
            end
         end
      end
      sb.delete();
      checks++;
      if (ar_cycles != 6) begin errors++; $display("FAIL stall_arvalid_cycles: got %0d required 6", ar_cycles); end
      checks++;
      if (addr_bad) begin errors++; $display("FAIL stall_araddr: got changing address required 80000100 throughout"); end
      checks++;
      if (dones != 1) begin errors++; $display("FAIL stall_done_count: got %0d required 1", dones); end
      ar_delay = 0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid_read();
      exp_t e;
      bit   reached = 0, got = 0, stale = 0, ar_seen = 0;
      int   lat = 0;
      r_hold = 1'b1;
      ifu_addr = 32'h3000_0040; ifu_req = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.m_rready) begin reached = 1; break; end
      end
      checks++;
      if (!reached) begin errors++; $display("FAIL mid_reset_reach_rdata: rready never seen"); end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.m_arvalid, bus.m_rready, bus.m_awvalid, bus.m_wvalid, bus.m_bready, ifu_done, lsu_done} !== 7'b0) begin
         errors++; $display("FAIL mid_reset_async: got ar=%b r=%b aw=%b w=%b b=%b done=%b%b required all 0",
                            bus.m_arvalid, bus.m_rready, bus.m_awvalid, bus.m_wvalid, bus.m_bready, ifu_done, lsu_done);
      end
      ifu_req = 1'b0; r_hold = 1'b0;
      @(negedge clk);
      checks++;
      if ({ifu_done, ifu_rdata, ifu_err, bus.m_rready, bus.m_arvalid, bus.m_araddr} !== '0) begin
         errors++; $display("FAIL mid_reset_outputs: got done=%b rdata=%h rready=%b arvalid=%b araddr=%h required all 0",
                            ifu_done, ifu_rdata, bus.m_rready, bus.m_arvalid, bus.m_araddr);
      end
      rst = 1'b0;
      @(negedge clk);
      rdata_val = 32'h1111_2222; ifu_addr = 32'h3000_0080; ifu_req = 1'b1;
      e.lsu = 1'b0; e.rdata = 32'h1111_2222; e.err = 1'b0; sb.push_back(e);
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (bus.m_arvalid && !ar_seen) begin
            ar_seen = 1;
            checks++;
            if (bus.m_araddr !== 32'h3000_0080) begin
               errors++; $display("FAIL post_reset_araddr: got %h required 30000080", bus.m_araddr);
            end
         end
         if (ifu_done && !ar_seen) stale = 1;
         if (ifu_done && ar_seen) begin lat = n; got = 1; break; end
      end
      checks++;
      if (stale || !got) begin errors++; $display("FAIL post_reset_done: got stale=%b completed=%b required 0/1", stale, got); end
      if (got && sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (lat != 3) begin errors++; $display("FAIL post_reset_latency: got %0d required 3", lat); end
         checks++;
         if ({ifu_rdata, ifu_err} !== {e.rdata, e.err}) begin
            errors++; $display("FAIL post_reset_data: got %h err=%b required %h err=%b", ifu_rdata, ifu_err, e.rdata, e.err);
         end
      end
      sb.delete();
      ifu_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      ifu_req = 1'b0; ifu_addr = '0;
      lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_ifu_read();
      test_lsu_write();
      test_arbitration();
      test_lsu_read_stall();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
